pgm_ddram_arbiter: RTL and testbench

- Shares the single DDRAM Avalon port between three PGM-side requesters: the ROM loader (writes), video/sprite fetch (reads) and the 68k program/data fetch (reads).
- Sits between the PGM core internals and the top-level DDRAM pins.
- Issues one 64-bit single-beat transaction at a time.
- Uses fixed priority, an anti-starvation promotion for the 68k, and a read timeout.

---
 rtl/pgm_ddram_arbiter_if.sv | 46 ++++
 rtl/pgm_ddram_arbiter.sv | 142 ++++++++++++++
 tb/tb_pgm_ddram_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pgm_ddram_arbiter_if.sv
// pgm_ddram_arbiter_if: requester and DDRAM Avalon signals shared by the PGM arbiter.
//   lw_*    : ROM loader write channel (req/addr/din/be in, ack out)
//   vr_*    : video/sprite read channel (req/addr in, dout/ack out)
//   cr_*    : 68k read channel (req/addr in, dout/ack out)
//   ddram_* : single-beat 64-bit Avalon port toward the DDRAM pins
//   timeout_err : sticky read-timeout flag
//   modport master : arbiter side; modport slave : requesters/DDRAM side
interface pgm_ddram_arbiter_if;
    logic        lw_req;
    logic [28:0] lw_addr;
    logic [63:0] lw_din;
    logic [7:0]  lw_be;
    logic        lw_ack;
    logic        vr_req;
    logic [28:0] vr_addr;
    logic [63:0] vr_dout;
    logic        vr_ack;
    logic        cr_req;
    logic [28:0] cr_addr;
    logic [63:0] cr_dout;
    logic        cr_ack;
    logic [28:0] ddram_addr;
    logic        ddram_rd;
    logic        ddram_we;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic [3:0]  ddram_burstcnt;
    logic [63:0] ddram_dout;
    logic        ddram_busy;
    logic        ddram_dout_ready;
    logic        timeout_err;

    modport master (
        input  lw_req, lw_addr, lw_din, lw_be, vr_req, vr_addr, cr_req, cr_addr,
               ddram_dout, ddram_busy, ddram_dout_ready,
        output lw_ack, vr_dout, vr_ack, cr_dout, cr_ack, ddram_addr, ddram_rd, ddram_we,
               ddram_din, ddram_be, ddram_burstcnt, timeout_err
    );

    modport slave (
        output lw_req, lw_addr, lw_din, lw_be, vr_req, vr_addr, cr_req, cr_addr,
               ddram_dout, ddram_busy, ddram_dout_ready,
        input  lw_ack, vr_dout, vr_ack, cr_dout, cr_ack, ddram_addr, ddram_rd, ddram_we,
               ddram_din, ddram_be, ddram_burstcnt, timeout_err
    );
endinterface

// File: rtl/pgm_ddram_arbiter.sv
// pgm_ddram_arbiter: shares one DDRAM Avalon port between loader writes, video reads and 68k reads.
//   clk_sys : system clock, rising edge
//   reset   : asynchronous active-high reset
//   bus     : pgm_ddram_arbiter_if.master (requester channels, DDRAM port, timeout_err)
// Fixed priority lw > vr > cr, with the 68k promoted over video after STARVE_LIMIT lost grants.
// Reads that never see ddram_dout_ready complete after TIMEOUT wait cycles with all-ones data.
module pgm_ddram_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 1023
) (
    input logic                 clk_sys,
    input logic                 reset,
    pgm_ddram_arbiter_if.master bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, ACK} state_t;
    typedef enum logic [1:0] {SEL_LW, SEL_VR, SEL_CR} sel_t;

    state_t        state, state_n;
    sel_t          sel, sel_n, win;
    logic [SW-1:0] starve, starve_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [28:0]   addr, addr_n;
    logic [63:0]   din, din_n, vr_dout, vr_dout_n, cr_dout, cr_dout_n, rdata;
    logic [7:0]    be, be_n;
    logic          rd, rd_n, we, we_n, terr, terr_n;
    logic          lw_ack, lw_ack_n, vr_ack, vr_ack_n, cr_ack, cr_ack_n;
    logic          any_req, promote, done;

    assign any_req = bus.lw_req | bus.vr_req | bus.cr_req;
    assign promote = bus.cr_req && starve >= SW'(STARVE_LIMIT);
    assign win     = bus.lw_req ? SEL_LW : promote ? SEL_CR : bus.vr_req ? SEL_VR : SEL_CR;
    // the cycle the counter would reach TIMEOUT is the last wait cycle
    assign done    = bus.ddram_dout_ready || tcnt == TW'(TIMEOUT - 1);
    assign rdata   = bus.ddram_dout_ready ? bus.ddram_dout : '1;

    always_comb begin
        state_n   = state;
        sel_n     = sel;
        starve_n  = starve;
        tcnt_n    = tcnt;
        addr_n    = addr;
        din_n     = din;
        be_n      = be;
        rd_n      = rd;
        we_n      = we;
        vr_dout_n = vr_dout;
        cr_dout_n = cr_dout;
        terr_n    = terr;
        lw_ack_n  = 1'b0;
        vr_ack_n  = 1'b0;
        cr_ack_n  = 1'b0;
        case (state)
            IDLE: begin
                starve_n = bus.cr_req ? starve : '0;
                if (any_req) begin
                    state_n  = CMD;
                    sel_n    = win;
                    starve_n = (win == SEL_CR || !bus.cr_req) ? '0 :
                               starve >= SW'(STARVE_LIMIT) ? starve : starve + 1'b1;
                    addr_n   = win == SEL_LW ? bus.lw_addr : win == SEL_VR ? bus.vr_addr : bus.cr_addr;
                    din_n    = win == SEL_LW ? bus.lw_din : din;
                    be_n     = win == SEL_LW ? bus.lw_be : 8'hFF;
                    we_n     = win == SEL_LW;
                    rd_n     = win != SEL_LW;
                end
            end
            CMD: begin
                if (!bus.ddram_busy) begin
                    rd_n     = 1'b0;
                    we_n     = 1'b0;
                    tcnt_n   = '0;
                    lw_ack_n = sel == SEL_LW;
                    state_n  = sel == SEL_LW ? ACK : WAIT;
                end
            end
            WAIT: begin
                tcnt_n = tcnt + 1'b1;
                if (done) begin
                    state_n   = ACK;
                    vr_ack_n  = sel == SEL_VR;
                    cr_ack_n  = sel == SEL_CR;
                    vr_dout_n = sel == SEL_VR ? rdata : vr_dout;
                    cr_dout_n = sel == SEL_CR ? rdata : cr_dout;
                    terr_n    = terr | !bus.ddram_dout_ready;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sel     <= SEL_LW;
            starve  <= '0;
            tcnt    <= '0;
            addr    <= '0;
            din     <= '0;
            be      <= '0;
            rd      <= 1'b0;
            we      <= 1'b0;
            vr_dout <= '0;
            cr_dout <= '0;
            terr    <= 1'b0;
            lw_ack  <= 1'b0;
            vr_ack  <= 1'b0;
            cr_ack  <= 1'b0;
        end else begin
            state   <= state_n;
            sel     <= sel_n;
            starve  <= starve_n;
            tcnt    <= tcnt_n;
            addr    <= addr_n;
            din     <= din_n;
            be      <= be_n;
            rd      <= rd_n;
            we      <= we_n;
            vr_dout <= vr_dout_n;
            cr_dout <= cr_dout_n;
            terr    <= terr_n;
            lw_ack  <= lw_ack_n;
            vr_ack  <= vr_ack_n;
            cr_ack  <= cr_ack_n;
        end
    end

    assign bus.ddram_addr     = addr;
    assign bus.ddram_din      = din;
    assign bus.ddram_be       = be;
    assign bus.ddram_rd       = rd;
    assign bus.ddram_we       = we;
    assign bus.ddram_burstcnt = 4'h1;
    assign bus.lw_ack         = lw_ack;
    assign bus.vr_ack         = vr_ack;
    assign bus.cr_ack         = cr_ack;
    assign bus.vr_dout        = vr_dout;
    assign bus.cr_dout        = cr_dout;
    assign bus.timeout_err    = terr;
endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// tb_pgm_ddram_arbiter: directed stimulus with a transaction-level model checked every cycle.
module tb_pgm_ddram_arbiter;
    localparam int LIMIT   = 4;
    localparam int TIMEOUT = 1023;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pgm_ddram_arbiter_if bus();
    pgm_ddram_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk), .reset(reset), .bus(bus));

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // requesters: each holds req while transactions remain, counting acks
    int lw_left = 0, vr_left = 0, cr_left = 0;
    initial begin
        bus.lw_req = 0; bus.lw_addr = 0; bus.lw_din = 0; bus.lw_be = 0;
        bus.vr_req = 0; bus.vr_addr = 0; bus.cr_req = 0; bus.cr_addr = 0;
        forever begin
            @(posedge clk); #1;
            if (bus.lw_ack && lw_left > 0) lw_left--;
            if (bus.vr_ack && vr_left > 0) vr_left--;
            if (bus.cr_ack && cr_left > 0) cr_left--;
            bus.lw_req = lw_left > 0;
            bus.vr_req = vr_left > 0;
            bus.cr_req = cr_left > 0;
        end
    end

    // DDRAM responder: busy for busy_len cycles per command, ready rdy_delay cycles after a read accept
    int busy_len = 0, rdy_delay = 1;
    logic [63:0] rdy_data = 0;
    int r_bleft = 0, r_rcnt = 0;
    logic r_seen = 0, r_rd = 0;
    initial begin
        bus.ddram_busy = 0; bus.ddram_dout_ready = 0; bus.ddram_dout = 0;
        forever begin
            @(posedge clk); #1;
            bus.ddram_dout_ready = 0;
            if (reset) r_seen = 0;
            else if ((bus.ddram_rd || bus.ddram_we) && !r_seen) begin
                r_seen = 1; r_rd = bus.ddram_rd; r_bleft = busy_len;
            end else if (r_seen && !bus.ddram_rd && !bus.ddram_we) begin
                r_seen = 0;
                if (r_rd && rdy_delay > 0) r_rcnt = rdy_delay;
            end
            if (r_rcnt > 0) begin
                r_rcnt--;
                if (r_rcnt == 0) bus.ddram_dout_ready = 1;
            end
            bus.ddram_busy = r_bleft > 0;
            if (r_bleft > 0) r_bleft--;
            bus.ddram_dout = bus.ddram_dout_ready ? rdy_data : {$urandom, $urandom};
        end
    end

    // transaction model: ph 0 free, 1 command on the bus, 2 awaiting read data, 3 ack cycle
    int ph = 0, w = 0, starve = 0, wcnt = 0;
    logic [28:0] w_addr = 0;
    logic [63:0] w_din = 0, m_vr = 0, m_cr = 0, m_d = 0;
    logic [7:0]  w_be = 0;
    logic        m_terr = 0;
    int ack_who[$], ack_cyc[$];
    int last_acc = -1, last_rdy = -1, rd_cyc = 0, we_cyc = 0;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_rd", 64'(bus.ddram_rd), 0);
            chk("rst_we", 64'(bus.ddram_we), 0);
            chk("rst_acks", 64'({bus.lw_ack, bus.vr_ack, bus.cr_ack}), 0);
            chk("rst_addr", 64'(bus.ddram_addr), 0);
            chk("rst_din", bus.ddram_din, 0);
            chk("rst_be", 64'(bus.ddram_be), 0);
            chk("rst_vr_dout", bus.vr_dout, 0);
            chk("rst_cr_dout", bus.cr_dout, 0);
            chk("rst_terr", 64'(bus.timeout_err), 0);
            ph = 0; starve = 0; m_terr = 0; m_vr = 0; m_cr = 0;
        end else begin
            chk("ddram_rd", 64'(bus.ddram_rd), 64'(ph == 1 && w != 0));
            chk("ddram_we", 64'(bus.ddram_we), 64'(ph == 1 && w == 0));
            chk("lw_ack", 64'(bus.lw_ack), 64'(ph == 3 && w == 0));
            chk("vr_ack", 64'(bus.vr_ack), 64'(ph == 3 && w == 1));
            chk("cr_ack", 64'(bus.cr_ack), 64'(ph == 3 && w == 2));
            chk("vr_dout", bus.vr_dout, m_vr);
            chk("cr_dout", bus.cr_dout, m_cr);
            chk("timeout_err", 64'(bus.timeout_err), 64'(m_terr));
            chk("burstcnt", 64'(bus.ddram_burstcnt), 1);
            if (ph == 1) begin
                chk("ddram_addr", 64'(bus.ddram_addr), 64'(w_addr));
                if (w == 0) begin
                    chk("ddram_din", bus.ddram_din, w_din);
                    chk("ddram_be", 64'(bus.ddram_be), 64'(w_be));
                end
            end
            if (bus.lw_ack) begin ack_who.push_back(0); ack_cyc.push_back(cyc); end
            if (bus.vr_ack) begin ack_who.push_back(1); ack_cyc.push_back(cyc); end
            if (bus.cr_ack) begin ack_who.push_back(2); ack_cyc.push_back(cyc); end
            if ((bus.ddram_rd || bus.ddram_we) && !bus.ddram_busy) last_acc = cyc;
            if (bus.ddram_dout_ready) last_rdy = cyc;
            if (bus.ddram_rd) rd_cyc++;
            if (bus.ddram_we) we_cyc++;
            case (ph)
                0: if (bus.lw_req || bus.vr_req || bus.cr_req) begin
                    if (bus.lw_req) w = 0;
                    else if (bus.cr_req && starve >= LIMIT) w = 2;
                    else if (bus.vr_req) w = 1;
                    else w = 2;
                    starve = (w == 2 || !bus.cr_req) ? 0 : (starve < LIMIT ? starve + 1 : starve);
                    w_addr = w == 0 ? bus.lw_addr : w == 1 ? bus.vr_addr : bus.cr_addr;
                    w_din = bus.lw_din;
                    w_be = bus.lw_be;
                    ph = 1;
                end else starve = 0;
                1: if (!bus.ddram_busy) begin
                    ph = w == 0 ? 3 : 2;
                    wcnt = 0;
                end
                2: begin
                    wcnt++;
                    if (bus.ddram_dout_ready || wcnt == TIMEOUT) begin
                        m_d = bus.ddram_dout_ready ? bus.ddram_dout : '1;
                        if (!bus.ddram_dout_ready) m_terr = 1;
                        if (w == 1) m_vr = m_d; else m_cr = m_d;
                        ph = 3;
                    end
                end
                default: ph = 0;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_acks(input int n, input int lim);
        int k = 0;
        while (ack_who.size() < n && k < lim) begin tick(1); k++; end
        chk("wait_bound", 64'(ack_who.size() >= n), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", passed, total);
        $fatal(1);
    end

    int n0, t_req, we0, rd0, acc0, vcnt, k;
    initial begin
        tick(3);
        chk("reset_rd_lit", 64'(bus.ddram_rd), 0);
        chk("reset_burst_lit", 64'(bus.ddram_burstcnt), 1);
        chk("reset_terr_lit", 64'(bus.timeout_err), 0);
        reset = 0;
        tick(2);

        // single loader write; later changes to lw inputs must not leak through
        busy_len = 0;
        bus.lw_addr = 29'h100; bus.lw_din = 64'h0123456789ABCDEF; bus.lw_be = 8'hFF;
        n0 = ack_who.size(); we0 = we_cyc;
        lw_left = 1;
        tick(1); t_req = cyc;
        tick(1);
        chk("w_we_lit", 64'(bus.ddram_we), 1);
        chk("w_addr_lit", 64'(bus.ddram_addr), 64'h100);
        chk("w_din_lit", bus.ddram_din, 64'h0123456789ABCDEF);
        chk("w_be_lit", 64'(bus.ddram_be), 64'hFF);
        bus.lw_addr = 29'h1FFF_FFFF; bus.lw_din = 64'h5555; bus.lw_be = 8'h0F;
        wait_acks(n0 + 1, 20);
        chk("w_ack_latency", 64'(ack_cyc[n0] - t_req), 2);
        chk("w_ack_who", 64'(ack_who[n0]), 0);
        tick(2);
        chk("w_we_cycles", 64'(we_cyc - we0), 1);

        // 68k read with 3 busy cycles and data 5 cycles after accept
        busy_len = 3; rdy_delay = 5; rdy_data = 64'hDEADBEEF00000001;
        bus.cr_addr = 29'h40;
        n0 = ack_who.size(); rd0 = rd_cyc;
        cr_left = 1;
        wait_acks(n0 + 1, 40);
        chk("r_rd_cycles", 64'(rd_cyc - rd0), 4);
        chk("r_ack_after_rdy", 64'(ack_cyc[n0] - last_rdy), 1);
        chk("r_ack_who", 64'(ack_who[n0]), 2);
        chk("r_cr_dout_lit", bus.cr_dout, 64'hDEADBEEF00000001);
        tick(2);

        // three simultaneous requests resolve lw, vr, cr
        busy_len = 0; rdy_delay = 2; rdy_data = 64'h1111_2222_3333_4444;
        bus.lw_addr = 29'h200; bus.lw_din = 64'hA5A5_0000_FFFF_1234; bus.lw_be = 8'h3C;
        bus.vr_addr = 29'h1234567; bus.cr_addr = 29'h0ABCDEF;
        n0 = ack_who.size();
        lw_left = 1; vr_left = 1; cr_left = 1;
        wait_acks(n0 + 3, 60);
        chk("sim_first_lw", 64'(ack_who[n0]), 0);
        chk("sim_second_vr", 64'(ack_who[n0 + 1]), 1);
        chk("sim_third_cr", 64'(ack_who[n0 + 2]), 2);
        tick(5);
        chk("sim_ack_count", 64'(ack_who.size() - n0), 3);

        // continuous video with a pending 68k: cr wins after every 4 video grants
        rdy_delay = 1; rdy_data = 64'h0BAD_F00D_0000_0007;
        bus.vr_addr = 29'h300; bus.cr_addr = 29'h301;
        n0 = ack_who.size();
        vr_left = 1000; cr_left = 3;
        k = 0;
        while (cr_left > 0 && k < 400) begin tick(1); k++; end
        chk("starve_cr_done", 64'(cr_left), 0);
        vr_left = 0;
        tick(10);
        vcnt = 0;
        for (int i = n0; i < ack_who.size(); i++) begin
            if (ack_who[i] == 1) vcnt++;
            else if (ack_who[i] == 2) begin
                chk("starve_gap", 64'(vcnt), 64'(LIMIT));
                vcnt = 0;
            end
        end

        // read that never gets data times out
        rdy_delay = 0;
        bus.cr_addr = 29'h55;
        n0 = ack_who.size();
        cr_left = 1;
        wait_acks(n0 + 1, 1100);
        chk("to_latency", 64'(ack_cyc[n0] - last_acc), 64'(TIMEOUT + 1));
        chk("to_dout_lit", bus.cr_dout, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("to_err_lit", 64'(bus.timeout_err), 1);
        rdy_delay = 3; rdy_data = 64'h0F0F_0F0F_F0F0_F0F0;
        bus.vr_addr = 29'h66;
        n0 = ack_who.size();
        vr_left = 1;
        wait_acks(n0 + 1, 40);
        chk("to_err_sticky", 64'(bus.timeout_err), 1);
        chk("to_next_vr_dout", bus.vr_dout, 64'h0F0F_0F0F_F0F0_F0F0);
        tick(2);

        // reset during a read wait abandons it; stale data later is ignored
        rdy_delay = 8; rdy_data = 64'hCAFE_CAFE_CAFE_CAFE;
        bus.vr_addr = 29'h77;
        n0 = ack_who.size(); acc0 = last_acc;
        vr_left = 1;
        k = 0;
        while (last_acc == acc0 && k < 20) begin tick(1); k++; end
        chk("rw_accept_bound", 64'(last_acc != acc0), 1);
        tick(1);
        reset = 1; vr_left = 0;
        #1;
        chk("rw_rd_lit", 64'(bus.ddram_rd), 0);
        chk("rw_we_lit", 64'(bus.ddram_we), 0);
        chk("rw_ack_lit", 64'(bus.vr_ack), 0);
        chk("rw_terr_lit", 64'(bus.timeout_err), 0);
        chk("rw_dout_lit", bus.vr_dout, 0);
        tick(2);
        reset = 0;
        tick(12);
        chk("rw_no_stale_ack", 64'(ack_who.size() - n0), 0);
        rdy_delay = 3; rdy_data = 64'h0123_4567_89AB_CDEF;
        vr_left = 1;
        wait_acks(n0 + 1, 40);
        chk("rw_next_who", 64'(ack_who[n0]), 1);
        chk("rw_next_dout_lit", bus.vr_dout, 64'h0123_4567_89AB_CDEF);
        tick(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
